car_sensor_driver: RTL

Generates the two-sensor waveform of a car passing the lot gate: the `outer` and `inner` beam signals that `CarDetection` consumes. On a one-cycle start command, it plays the full entry or exit sensor sequence with a programmable dwell per phase, then pulses `done`. It sits on the stimulus side of the gate logic, for bench loopback and for the on-board demo mode, where it replaces the physical sensors.

---
 rtl/car_sensor_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/car_sensor_driver.sv
// car_sensor_driver
// Plays the two-beam (outer, inner) waveform of a car passing the lot gate.
// A one-cycle start in IDLE launches an entry or exit sequence of three
// beam phases plus a clear gap, each lasting a latched dwell of D cycles.
// The block then pulses done for one cycle.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start_enter  request entry sequence (sampled in IDLE only)
//   start_exit   request exit sequence (sampled in IDLE only)
//   abort        synchronous cancel of a running sequence
//   dwell        cycles per phase, latched at start, 0 behaves as 1
//   outer/inner  beam-blocked outputs (registered)
//   busy         sequence in progress (registered)
//   done         one-cycle completion pulse (registered)
//   dir          direction of last accepted sequence, 1 = enter (registered)
module car_sensor_driver #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_enter,
   input  logic               start_exit,
   input  logic               abort,
   input  logic [DWELL_W-1:0] dwell,
   output logic               outer,
   output logic               inner,
   output logic               busy,
   output logic               done,
   output logic               dir
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PH1  = 3'd1,
      S_PH2  = 3'd2,
      S_PH3  = 3'd3,
      S_GAP  = 3'd4
   } state_e;

   state_e             state_q;
   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] reload_q;
   logic               outer_q;
   logic               inner_q;
   logic               busy_q;
   logic               done_q;
   logic               dir_q;

   // Exactly one start request is a valid launch; both together is ambiguous.
   logic               start_ok_c;
   // Reload value D-1 with a zero dwell clamped to one cycle per phase.
   logic [DWELL_W-1:0] dwell_m1_c;

   assign start_ok_c = start_enter ^ start_exit;
   assign dwell_m1_c = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

   // Beam pattern {outer, inner} for a given phase and direction.
   function automatic logic [1:0] beams(input state_e s, input logic ent);
      logic [1:0] b;
      b = 2'b00;
      case (s)
         S_PH1:   b = ent ? 2'b10 : 2'b01;
         S_PH2:   b = 2'b11;
         S_PH3:   b = ent ? 2'b01 : 2'b10;
         default: b = 2'b00;
      endcase
      return b;
   endfunction

   // Phase succession; GAP is handled separately because it ends the run.
   function automatic state_e next_phase(input state_e s);
      state_e n;
      n = S_IDLE;
      case (s)
         S_PH1:   n = S_PH2;
         S_PH2:   n = S_PH3;
         S_PH3:   n = S_GAP;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

   // Sequencer: state, dwell counter and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         outer_q  <= 1'b0;
         inner_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dir_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // abort in IDLE only has the effect of masking a start.
               if (!abort && start_ok_c) begin
                  state_q            <= S_PH1;
                  dir_q              <= start_enter;
                  reload_q           <= dwell_m1_c;
                  cnt_q              <= dwell_m1_c;
                  busy_q             <= 1'b1;
                  {outer_q, inner_q} <= beams(S_PH1, start_enter);
               end
            end
            S_PH1, S_PH2, S_PH3, S_GAP: begin
               if (abort) begin
                  state_q            <= S_IDLE;
                  cnt_q              <= '0;
                  busy_q             <= 1'b0;
                  {outer_q, inner_q} <= 2'b00;
               end else if (cnt_q == '0) begin
                  cnt_q <= reload_q;
                  if (state_q == S_GAP) begin
                     state_q            <= S_IDLE;
                     busy_q             <= 1'b0;
                     done_q             <= 1'b1;
                     {outer_q, inner_q} <= 2'b00;
                  end else begin
                     state_q            <= next_phase(state_q);
                     {outer_q, inner_q} <= beams(next_phase(state_q), dir_q);
                  end
               end else begin
                  cnt_q <= cnt_q - DWELL_W'(1);
               end
            end
            default: begin
               // Unreachable encodings recover to a quiet IDLE.
               state_q            <= S_IDLE;
               cnt_q              <= '0;
               busy_q             <= 1'b0;
               {outer_q, inner_q} <= 2'b00;
            end
         endcase
      end
   end

   assign outer = outer_q;
   assign inner = inner_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign dir   = dir_q;

endmodule
